rst_seq: RTL and testbench

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_seq_pkg.sv | 37 +++
 rtl/rst_sync.sv | 24 ++
 rtl/rst_seq.sv | 133 +++++++++++++
 tb/tb_rst_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared reset package.
// Holds the reset-manager source type, the rst_seq FSM state type, the
// default release/pulse timing constants and a lowest-set-bit helper used
// to arbitrate software reset requests.
package rst_seq_pkg;

  // Reset sources as seen by the reset manager.
  typedef enum logic [1:0] {
    RST_SRC_NONE = 2'd0,
    RST_SRC_POR  = 2'd1,
    RST_SRC_SYS  = 2'd2,
    RST_SRC_SW   = 2'd3
  } rst_src_e;

  // Reset sequencer FSM states.
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2,
    SWRST   = 2'd3
  } rst_seq_e;

  localparam int unsigned DLY_CYC_DEF   = 16;
  localparam int unsigned PULSE_CYC_DEF = 8;
  localparam int unsigned CNT_W         = 8;

  // Index of the lowest set bit of v (0 when v is all zero).
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchronizer: asynchronous clear, synchronous release.
// Ports:
//   clk    - destination clock
//   clr_n  - active-low asynchronous clear
//   sync_n - synchronized active-low reset, rises two clk edges after clr_n
module rst_sync (
  input  logic clk,
  input  logic clr_n,
  output logic sync_n
);

  logic meta;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      meta   <= 1'b0;
      sync_n <= 1'b0;
    end else begin
      meta   <= 1'b1;
      sync_n <= meta;
    end
  end

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: releases NUM_DOM downstream reset domains one after the
// other, DLY_CYC cycles apart, once the synchronized system reset rises, and
// then serves per-domain software reset requests with a PULSE_CYC-cycle pulse.
// Ports:
//   clk_i        - system clock
//   rst_ni       - asynchronous active-low power-on reset
//   sys_rst_ni   - active-low system reset from the reset manager
//   sw_rst_req_i - level software reset request, one bit per domain
//   dom_rst_no   - active-low per-domain reset, bit 0 released first
//   sw_rst_ack_o - one-cycle pulse when a software reset completes
//   seq_done_o   - all domains released and no software reset active
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOM   = 4,
  parameter int unsigned DLY_CYC   = DLY_CYC_DEF,
  parameter int unsigned PULSE_CYC = PULSE_CYC_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               sys_rst_ni,
  input  logic [NUM_DOM-1:0] sw_rst_req_i,
  output logic [NUM_DOM-1:0] dom_rst_no,
  output logic [NUM_DOM-1:0] sw_rst_ack_o,
  output logic               seq_done_o
);

  localparam int unsigned IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [CNT_W-1:0] DLY_TC   = CNT_W'(DLY_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_TC = CNT_W'(PULSE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOM - 1);

  logic               sync_rst_n;
  logic               clr_n;
  rst_seq_e           state_q, state_d;
  logic [NUM_DOM-1:0] rel_q, rel_d;
  logic [NUM_DOM-1:0] ack_q, ack_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   req_sel;

  // Either reset source clears the synchronizer immediately.
  assign clr_n = rst_ni & sys_rst_ni;

  rst_sync u_sync (
    .clk    (clk_i),
    .clr_n  (clr_n),
    .sync_n (sync_rst_n)
  );

  assign req_sel = IDX_W'(lowest_set(8'(sw_rst_req_i)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HOLD;
      rel_q   <= '0;
      ack_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rel_d   = rel_q;
    ack_d   = '0;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    if (!sync_rst_n) begin
      // Any reset drops everything; a pending ack is simply never raised.
      state_d = HOLD;
      rel_d   = '0;
      cnt_d   = '0;
      idx_d   = '0;
      sel_d   = '0;
    end else begin
      unique case (state_q)
        // The HOLD exit cycle already counts as the first delay cycle, so
        // domain k is released exactly (k+1)*DLY_CYC cycles after
        // sync_rst_n rises. HOLD always holds cnt/idx at zero here.
        HOLD, RELEASE: begin
          state_d = RELEASE;
          if (cnt_q == DLY_TC) begin
            rel_d[idx_q] = 1'b1;
            cnt_d        = '0;
            idx_d        = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
              idx_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (|sw_rst_req_i) begin
            sel_d          = req_sel;
            rel_d[req_sel] = 1'b0;
            cnt_d          = '0;
            state_d        = SWRST;
          end
        end
        SWRST: begin
          if (cnt_q == PULSE_TC) begin
            rel_d[sel_q] = 1'b1;
            ack_d[sel_q] = 1'b1;
            cnt_d        = '0;
            state_d      = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = HOLD;
      endcase
    end
  end

  // Assertion follows sync_rst_n asynchronously; release is registered.
  assign dom_rst_no   = rel_q & {NUM_DOM{sync_rst_n}};
  assign sw_rst_ack_o = ack_q;
  assign seq_done_o   = (state_q == DONE);

endmodule

// File: tb/tb_rst_seq.sv
module tb_rst_seq;

  localparam int N     = 4;
  localparam int DLY   = 16;
  localparam int PULSE = 8;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         sys_rst_ni;
  logic [N-1:0] sw_rst_req_i;
  logic [N-1:0] dom_rst_no;
  logic [N-1:0] sw_rst_ack_o;
  logic         seq_done_o;

  rst_seq #(.NUM_DOM(N), .DLY_CYC(DLY), .PULSE_CYC(PULSE)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .sys_rst_ni   (sys_rst_ni),
    .sw_rst_req_i (sw_rst_req_i),
    .dom_rst_no   (dom_rst_no),
    .sw_rst_ack_o (sw_rst_ack_o),
    .seq_done_o   (seq_done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [N-1:0] dom;
    logic [N-1:0] ack;
    logic         done;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  // Reference model: time-stamp based. e0 is the edge at which the
  // synchronized reset rises; releases follow from (n-e0)/DLY.
  int           streak  = 0;
  int           e0      = -1;
  int           sw_dom  = -1;
  int           sw_end  = 0;
  bit           done_ph = 1'b0;
  logic         m_sync  = 1'b0;
  logic [N-1:0] m_rel   = '0;
  logic [N-1:0] m_ack   = '0;
  logic [N-1:0] req     = '0;
  logic [2*N:0] last_vis = '0;

  task automatic model_edge(input int n);
    int k;
    streak = (rst_ni && sys_rst_ni) ? streak + 1 : 0;
    m_ack  = '0;
    if (!m_sync) begin
      e0      = -1;
      m_rel   = '0;
      done_ph = 1'b0;
      sw_dom  = -1;
      if (streak == 2) e0 = n;
    end else if (!done_ph) begin
      k = (n - e0) / DLY;
      if (k >= N) begin
        k       = N;
        done_ph = 1'b1;
      end
      m_rel = N'((1 << k) - 1);
    end else if (sw_dom >= 0) begin
      if (n == sw_end) begin
        m_rel[sw_dom] = 1'b1;
        m_ack[sw_dom] = 1'b1;
        sw_dom        = -1;
      end
    end else if (req != '0) begin
      for (int i = N - 1; i >= 0; i--) if (req[i]) sw_dom = i;
      m_rel[sw_dom] = 1'b0;
      sw_end        = n + PULSE;
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic [N-1:0] add);
    logic [2*N:0] vis;
    ev_t          e;
    @(posedge clk);
    #2;
    model_edge(cyc);
    // Requesters drop their bit once acknowledged.
    req          = (req & ~m_ack) | add;
    rst_ni       = r;
    sys_rst_ni   = s;
    sw_rst_req_i = req;
    m_sync       = r && s && (streak >= 2);
    vis = {m_rel & {N{m_sync}}, m_ack, done_ph && (sw_dom < 0)};
    if (vis != last_vis) begin
      e.cyc  = cyc;
      e.dom  = vis[2*N:N+1];
      e.ack  = vis[N:1];
      e.done = vis[0];
      exp_q.push_back(e);
      last_vis = vis;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b1, 1'b1, '0);
  endtask

  task automatic wait_mask(input logic [N-1:0] target, input int budget);
    int t;
    t = 0;
    while (!(m_sync && m_rel == target) && t < budget) begin
      tick(1'b1, 1'b1, '0);
      t++;
    end
    if (t >= budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_mask timeout: reached %b required %b", m_rel, target);
    end
  endtask

  // Monitor: every change on the outputs must match the next expected event.
  bit           mon_en   = 1'b0;
  logic [2*N:0] mon_prev = '0;
  logic [2*N:0] cur;
  ev_t          me;

  always @(negedge clk) begin
    if (mon_en) begin
      cur = {dom_rst_no, sw_rst_ack_o, seq_done_o};
      if (cur !== mon_prev) begin
        mon_prev = cur;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change cyc=%0d got dom=%b ack=%b done=%b, required no change",
                   cyc, dom_rst_no, sw_rst_ack_o, seq_done_o);
        end else begin
          me = exp_q.pop_front();
          if (me.cyc != cyc || me.dom !== dom_rst_no || me.ack !== sw_rst_ack_o ||
              me.done !== seq_done_o) begin
            n_err++;
            $display("FAIL output_event got cyc=%0d dom=%b ack=%b done=%b, required cyc=%0d dom=%b ack=%b done=%b",
                     cyc, dom_rst_no, sw_rst_ack_o, seq_done_o, me.cyc, me.dom, me.ack, me.done);
          end
        end
      end
    end
  end

  initial begin
    int hold;
    rst_ni       = 1'b0;
    sys_rst_ni   = 1'b1;
    sw_rst_req_i = '0;

    repeat (2) @(negedge clk);
    n_cmp++;
    if (dom_rst_no !== '0) begin
      n_err++;
      $display("FAIL reset_dom got %b required 0000", dom_rst_no);
    end
    n_cmp++;
    if (sw_rst_ack_o !== '0) begin
      n_err++;
      $display("FAIL reset_ack got %b required 0000", sw_rst_ack_o);
    end
    n_cmp++;
    if (seq_done_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done got %b required 0", seq_done_o);
    end
    mon_en = 1'b1;

    // Power-on sequence.
    tick(1'b0, 1'b1, '0);
    tick(1'b1, 1'b1, '0);
    run(80);

    // Single software reset on domain 2.
    tick(1'b1, 1'b1, 4'b0100);
    run(20);

    // Simultaneous requests, domain 1 then domain 3.
    tick(1'b1, 1'b1, 4'b1010);
    run(40);

    // System reset pulse mid-sequence.
    tick(1'b1, 1'b0, '0);
    wait_mask(4'b0011, 100);
    tick(1'b1, 1'b0, '0);
    run(90);

    // System reset during a software reset pulse; request stays held.
    tick(1'b1, 1'b1, 4'b0001);
    run(4);
    tick(1'b1, 1'b0, '0);
    run(100);

    // Request raised while still releasing.
    tick(1'b1, 1'b0, '0);
    wait_mask(4'b0001, 100);
    tick(1'b1, 1'b1, 4'b0001);
    run(90);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        hold = $urandom_range(1, 3);
        repeat (hold) tick(1'b1, 1'b0, '0);
      end else if ($urandom_range(0, 19) == 0) begin
        tick(1'b1, 1'b1, N'($urandom_range(1, 15)));
      end else begin
        tick(1'b1, 1'b1, '0);
      end
    end
    run(120);

    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_events got %0d outstanding, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
